reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Board-level reset sequencer between the PLL and the Quokka main controller.
//  Synchronises the asynchronous PLL lock and reset button into the system clock domain,
//  qualifies lock stability, and holds the core in reset long enough for BRAM initialisation.
//  Drives the controller's reset and reports why the last reset happened.
//  Replaces ad-hoc reset counters in board top files.
// PARAMETERS
//  SYNC_STAGES        2      flops in each async-input synchroniser chain (>=2)
//  LOCK_STABLE_CYCLES 1024   consecutive synced-lock-high cycles required before HOLD
//  HOLD_CYCLES        63     cycles CoreReset stays high after lock qualified (BRAM init margin)
//  DEBOUNCE_CYCLES    65536  cycles synced button must be stable before debounced level changes
//  LOSS_CNT_W         8      width of lock-loss event counter
// PORTS
//  Clock          in   1           system clock (PLL 50 MHz output)
//  Reset          in   1           synchronous, active-high
//  PllLocked      in   1           PLL LOCKED, asynchronous to Clock
//  ResetBtn       in   1           board button, active-high, asynchronous, bouncing
//  CoreReset      out  1           active-high reset to controller, registered
//  Running        out  1           1 when FSM is in RUN, registered
//  ResetCause     out  2           00 POR, 01 LOCK_LOSS, 10 BUTTON; 11 unused
//  LockLossCount  out  LOSS_CNT_W  number of RUN->lock-loss events, saturating
// BEHAVIOUR
//  - Reset: state=WAIT_LOCK, CoreReset=1, Running=0, ResetCause=00, LockLossCount=0;
//    sync chains, debounce counter, debounced button and cycle counter all cleared to 0.
//  - lock_s = PllLocked after SYNC_STAGES flops.
//  - btn_db = debounced level of the synced ResetBtn.
//  - btn_rise = btn_db 0->1 edge, one cycle wide.
//  - Debounce: counter clears whenever synced button equals btn_db.
//    Otherwise it increments; at DEBOUNCE_CYCLES-1 btn_db toggles and the counter clears.
//  - FSM, one 2-state-bit-min enum, cycle counter cnt:
//    WAIT_LOCK: lock_s=1 -> QUALIFY, cnt=0.
//    QUALIFY:   lock_s=0 -> WAIT_LOCK.
//               Else cnt++. At cnt==LOCK_STABLE_CYCLES-1 -> HOLD, cnt=0.
//    HOLD:      lock_s=0 -> WAIT_LOCK, cause=LOCK_LOSS.
//               Else btn_db=1 -> stay, cnt=0 (reset held while pressed).
//               Else cnt++. At cnt==HOLD_CYCLES-1 -> RUN.
//    RUN:       lock_s=0 -> WAIT_LOCK, cause=LOCK_LOSS, LockLossCount++ (saturate at all-ones).
//               Else btn_rise -> HOLD, cnt=0, cause=BUTTON.
//  - Simultaneous lock loss and btn_rise in RUN: lock loss wins. Cause=LOCK_LOSS, count increments.
//  - CoreReset <= (next_state != RUN); Running <= (next_state == RUN). Both change on the same edge.
//  - Latency: edge 0 is the first edge sampling PllLocked=1, with the button idle.
//    CoreReset falls after edge SYNC_STAGES+LOCK_STABLE_CYCLES+HOLD_CYCLES.
//  - Lock-loss response: CoreReset rises after edge SYNC_STAGES, counting from the first edge that samples PllLocked=0.
//  - ResetCause is sticky: it is updated only on the transitions listed above and held through RUN.
//  - Reset asserted mid-sequence: immediate return to reset values on the next edge. No partial counts survive.
//  - Counter widths are $clog2(max(LOCK_STABLE_CYCLES,HOLD_CYCLES)) and $clog2(DEBOUNCE_CYCLES).
//    No wrap is possible within a state.
// STRUCTURE
//  - Package reset_seq_pkg:
//    state enum {WAIT_LOCK, QUALIFY, HOLD, RUN};
//    cause constants CAUSE_POR=2'b00, CAUSE_LOCK_LOSS=2'b01, CAUSE_BUTTON=2'b10.
//  - Sub-module sync_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES; ports Clock, Reset, AsyncIn, Level, Rise).
//    One instance for ResetBtn.
//    One instance for PllLocked with DEBOUNCE_CYCLES=1, i.e. plain synchroniser; the FSM qualifies lock itself.
//  - Top body: FSM, cycle counter, cause register, loss counter, output registers.
// TESTING (bench params SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, DEBOUNCE_CYCLES=5)
//  1. Reset 3 cycles, then PllLocked=1 -> CoreReset=1 through edge 13. CoreReset=0 and Running=1 after edge 14. ResetCause=00.
//  2. PllLocked glitches low for 1 cycle during QUALIFY -> FSM returns to WAIT_LOCK.
//     CoreReset stays 1; full 14-edge sequence restarts from the relock. LockLossCount=0.
//  3. In RUN, drop PllLocked -> CoreReset=1 after edge 2, ResetCause=01, LockLossCount=1.
//     Relock -> RUN again after 14 edges.
//  4. In RUN, ResetBtn bounces 1/0/1 within 3 cycles, then holds 1 for 10 cycles:
//     - no reset from the bounce;
//     - after debounce, CoreReset=1 and ResetCause=10;
//     - Running returns 1 exactly HOLD_CYCLES=4 edges after btn_db falls following release.
//  5. In RUN, btn_rise and lock_s fall on the same edge -> ResetCause=01, LockLossCount increments, state=WAIT_LOCK.
//  6. 256 lock-loss events with LOSS_CNT_W=8 -> LockLossCount holds 255.
//     Reset mid-HOLD -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and constants for the board reset sequencer.
//   - state_e     : sequencer FSM states
//   - CAUSE_*     : encodings reported on ResetCause_o
//   - cnt_width() : width of a counter that must hold values up to max(a,b)-1
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      QUALIFY   = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_POR       = 2'b00;
   localparam logic [1:0] CAUSE_LOCK_LOSS = 2'b01;
   localparam logic [1:0] CAUSE_BUTTON    = 2'b10;

   // Counter only ever has to reach max(a,b)-1, so $clog2(max) bits suffice.
   // Clamped to 1 bit so degenerate parameters never give a zero-width vector.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//   Brings an asynchronous level into the Clock_i domain through a SYNC_STAGES
//   flop chain, then optionally debounces it.
//   With DEBOUNCE_CYCLES <= 1 the debouncer is bypassed and Level_o is the raw
//   synchroniser output (no extra latency).
//   Otherwise Level_o changes only after the synced input has differed from it
//   for DEBOUNCE_CYCLES consecutive cycles.
// Ports
//   Clock_i   : system clock
//   Reset_i   : synchronous, active-high; clears chain, counter and level
//   AsyncIn_i : asynchronous input
//   Level_o   : synchronised (and debounced) level
//   Rise_o    : one-cycle pulse on each 0->1 change of Level_o
// -----------------------------------------------------------------------------
module sync_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
   input  logic Clock_i,
   input  logic Reset_i,
   input  logic AsyncIn_i,
   output logic Level_o,
   output logic Rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   level;
   logic                   level_prev_q;

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], AsyncIn_i};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   if (DEBOUNCE_CYCLES > 1) begin : g_db
      localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            db_q, db_d;

      // Any cycle where the input agrees with the current level restarts the
      // stability window, so bounces shorter than the window are swallowed.
      always_comb begin
         cnt_d = '0;
         db_d  = db_q;
         if (synced != db_q) begin
            if (cnt_q == DB_LAST) begin
               db_d = ~db_q;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge Clock_i) begin
         if (Reset_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
         end
      end

      assign level = db_q;
   end else begin : g_nodb
      assign level = synced;
   end

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level;
      end
   end

   assign Level_o = level;
   assign Rise_o  = level & ~level_prev_q;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Board-level reset sequencer between the PLL and the main controller.
//   Waits for a stable PLL lock, holds the core in reset for HOLD_CYCLES of
//   BRAM init margin, then releases it. Lock loss or a debounced button press
//   puts the core back into reset; the reason is reported on ResetCause_o.
// Ports
//   Clock_i         : system clock (PLL output)
//   Reset_i         : synchronous, active-high
//   PllLocked_i     : PLL lock, asynchronous
//   ResetBtn_i      : board button, active-high, asynchronous, bouncing
//   CoreReset_o     : active-high reset to the controller, registered
//   Running_o       : 1 while the sequencer is in RUN, registered
//   ResetCause_o    : 00 POR, 01 lock loss, 10 button (sticky)
//   LockLossCount_o : saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES        = 63,
   parameter int unsigned DEBOUNCE_CYCLES    = 65536,
   parameter int unsigned LOSS_CNT_W         = 8
) (
   input  logic                  Clock_i,
   input  logic                  Reset_i,
   input  logic                  PllLocked_i,
   input  logic                  ResetBtn_i,
   output logic                  CoreReset_o,
   output logic                  Running_o,
   output logic [1:0]            ResetCause_o,
   output logic [LOSS_CNT_W-1:0] LockLossCount_o
);

   localparam int unsigned      CNT_W     = cnt_width(LOCK_STABLE_CYCLES, HOLD_CYCLES);
   localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // Input conditioning. Lock is only synchronised; its stability is judged by
   // the QUALIFY state instead of a debouncer.
   // ---------------------------------------------------------------------------
   logic lock_s;
   logic lock_rise_unused;
   logic btn_db;
   logic btn_rise;

   sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (1)
   ) u_lock_sync (
      .Clock_i   (Clock_i),
      .Reset_i   (Reset_i),
      .AsyncIn_i (PllLocked_i),
      .Level_o   (lock_s),
      .Rise_o    (lock_rise_unused)
   );

   sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .Clock_i   (Clock_i),
      .Reset_i   (Reset_i),
      .AsyncIn_i (ResetBtn_i),
      .Level_o   (btn_db),
      .Rise_o    (btn_rise)
   );

   // ---------------------------------------------------------------------------
   // Sequencer state
   // ---------------------------------------------------------------------------
   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              cause_q, cause_d;
   logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
   logic                    core_reset_q;
   logic                    running_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      loss_d  = loss_q;

      unique case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = QUALIFY;
               cnt_d   = '0;
            end
         end

         // Lock has to stay high for LOCK_STABLE_CYCLES in a row; any dropout
         // starts over from WAIT_LOCK. Not reported as a lock loss because the
         // core never left reset.
         QUALIFY: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == QUAL_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // The hold window restarts while the button is still down, so the
         // core leaves reset HOLD_CYCLES after release is debounced.
         HOLD: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cause_d = CAUSE_LOCK_LOSS;
            end else if (btn_db) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Lock loss takes priority over a simultaneous button press.
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cause_d = CAUSE_LOCK_LOSS;
               if (loss_q != '1) begin
                  loss_d = loss_q + LOSS_CNT_W'(1);
               end
            end else if (btn_rise) begin
               state_d = HOLD;
               cnt_d   = '0;
               cause_d = CAUSE_BUTTON;
            end
         end

         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so CoreReset_o and Running_o
   // switch on the same edge as the state register.
   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q      <= WAIT_LOCK;
         cnt_q        <= '0;
         cause_q      <= CAUSE_POR;
         loss_q       <= '0;
         core_reset_q <= 1'b1;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cause_q      <= cause_d;
         loss_q       <= loss_d;
         core_reset_q <= (state_d != RUN);
         running_q    <= (state_d == RUN);
      end
   end

   assign CoreReset_o     = core_reset_q;
   assign Running_o       = running_q;
   assign ResetCause_o    = cause_q;
   assign LockLossCount_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with SYNC_STAGES=2,
//   LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, DEBOUNCE_CYCLES=5, LOSS_CNT_W=8.
//   Inputs change 1 time unit after a rising edge; "edge n" below is the n-th
//   rising edge that samples the new input value. Outputs are sampled 1 time
//   unit after the edge under test.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       pll;
   logic       btn;
   logic       core_rst;
   logic       running;
   logic [1:0] cause;
   logic [7:0] loss;

   int n_cmp = 0;
   int n_bad = 0;

   reset_sequencer #(
      .SYNC_STAGES        (2),
      .LOCK_STABLE_CYCLES (8),
      .HOLD_CYCLES        (4),
      .DEBOUNCE_CYCLES    (5),
      .LOSS_CNT_W         (8)
   ) dut (
      .Clock_i         (clk),
      .Reset_i         (rst),
      .PllLocked_i     (pll),
      .ResetBtn_i      (btn),
      .CoreReset_o     (core_rst),
      .Running_o       (running),
      .ResetCause_o    (cause),
      .LockLossCount_o (loss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      pll = 1'b0;
      btn = 1'b0;

      // 1. Power-on: reset values, then 14-edge lock-to-run latency.
      step(3);
      chk("por_corereset", core_rst, 1);
      chk("por_running",   running,  0);
      chk("por_cause",     cause,    0);
      chk("por_losscnt",   loss,     0);
      rst = 1'b0;
      pll = 1'b1;
      step(14);                              // edges 0..13
      chk("t1_corereset_e13", core_rst, 1);
      chk("t1_running_e13",   running,  0);
      step(1);                               // edge 14
      chk("t1_corereset_e14", core_rst, 0);
      chk("t1_running_e14",   running,  1);
      chk("t1_cause",         cause,    0);

      // 2. One-cycle lock glitch during QUALIFY restarts the whole sequence.
      rst = 1'b1;
      pll = 1'b0;
      step(3);
      rst = 1'b0;
      pll = 1'b1;
      step(6);                               // edges 0..5, QUALIFY from edge 2
      pll = 1'b0;
      step(1);                               // edge 6 samples the glitch
      pll = 1'b1;
      step(14);                              // new edges 0..13
      chk("t2_corereset_hold", core_rst, 1);
      chk("t2_running_hold",   running,  0);
      step(1);                               // new edge 14
      chk("t2_corereset_run",  core_rst, 0);
      chk("t2_running_run",    running,  1);
      chk("t2_losscnt",        loss,     0);
      chk("t2_cause",          cause,    0);

      // 3. Lock loss in RUN: reset reasserted after edge 2, then relock.
      pll = 1'b0;
      step(2);                               // edges 0,1
      chk("t3_corereset_e1", core_rst, 0);
      step(1);                               // edge 2
      chk("t3_corereset_e2", core_rst, 1);
      chk("t3_running_e2",   running,  0);
      chk("t3_cause",        cause,    1);
      chk("t3_losscnt",      loss,     1);
      step(3);
      pll = 1'b1;
      step(14);
      chk("t3_relock_e13",   core_rst, 1);
      step(1);
      chk("t3_relock_run",   running,  1);
      chk("t3_relock_crst",  core_rst, 0);
      chk("t3_cause_sticky", cause,    1);

      // 4. Button bounce 1/0/1 then held 10 cycles. Debounced level rises
      //    after edge 8 (FSM reacts at edge 9) and falls after edge 18; RUN
      //    returns four edges later at edge 22.
      btn = 1'b1;
      step(1);                               // edge 0
      btn = 1'b0;
      step(1);                               // edge 1
      btn = 1'b1;
      step(7);                               // edges 2..8
      chk("t4_no_reset_bounce", core_rst, 0);
      chk("t4_running_bounce",  running,  1);
      step(1);                               // edge 9
      chk("t4_corereset_btn",   core_rst, 1);
      chk("t4_cause_btn",       cause,    2);
      chk("t4_running_btn",     running,  0);
      step(2);                               // edges 10,11
      btn = 1'b0;
      step(10);                              // edges 12..21
      chk("t4_running_e21",     running,  0);
      chk("t4_corereset_e21",   core_rst, 1);
      step(1);                               // edge 22
      chk("t4_running_e22",     running,  1);
      chk("t4_corereset_e22",   core_rst, 0);
      chk("t4_cause_sticky",    cause,    2);

      // 5. btn_rise and lock_s fall seen by the FSM on the same edge (7).
      btn = 1'b1;
      step(5);                               // edges 0..4
      pll = 1'b0;
      step(2);                               // edges 5,6
      chk("t5_still_run",      running,  1);
      step(1);                               // edge 7
      chk("t5_corereset",      core_rst, 1);
      chk("t5_running",        running,  0);
      chk("t5_cause_lockloss", cause,    1);
      chk("t5_losscnt",        loss,     2);
      btn = 1'b0;
      step(12);
      chk("t5_wait_corereset", core_rst, 1);
      chk("t5_wait_cause",     cause,    1);

      // 6. Saturating lock-loss counter: 254 more events make 256 in total.
      for (int i = 0; i < 254; i++) begin
         pll = 1'b1;
         step(15);
         chk("t6_run", running, 1);
         pll = 1'b0;
         step(3);
         chk("t6_losscnt", loss, ((3 + i) > 255) ? 255 : (3 + i));
      end
      chk("t6_losscnt_sat", loss, 255);

      // Reset during HOLD clears everything; the next sequence is a full one.
      pll = 1'b1;
      step(12);                              // edges 0..11, HOLD from edge 10
      chk("t6_in_hold", core_rst, 1);
      rst = 1'b1;
      step(1);
      chk("t6_rst_corereset", core_rst, 1);
      chk("t6_rst_running",   running,  0);
      chk("t6_rst_cause",     cause,    0);
      chk("t6_rst_losscnt",   loss,     0);
      rst = 1'b0;
      step(14);
      chk("t6_post_e13", core_rst, 1);
      step(1);
      chk("t6_post_e14_run",  running,  1);
      chk("t6_post_e14_crst", core_rst, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
